// File: rtl/data_mem_responder.sv
// Latency-modelling word memory behind a valid/ready load/store port; responds LATENCY+1 edges after accept.
// rsp_ready low holds the response stable and keeps req_ready low; one transaction is in flight at a time.
module data_mem_responder #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DEPTH_LOG2    = 8,
  parameter int LATENCY       = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  input  logic [3:0]               req_be,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                   state;
  logic [3:0]               cnt;
  logic                     lat_we;
  logic [ADDRESS_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0]    lat_wdata;
  logic [3:0]               lat_be;

  logic [DATA_WIDTH-1:0]    mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0]    idx;
  logic                     acc_err;
  logic                     access;
  logic                     mem_wr;

  assign idx     = lat_addr[DEPTH_LOG2+1:2];
  assign acc_err = (lat_addr[1:0] != 2'b00) || ((lat_addr >> (DEPTH_LOG2 + 2)) != '0);
  assign access  = (state == S_WAIT) && (cnt == 4'd0);
  // A reset landing on the access edge drops the pending store.
  assign mem_wr  = access && !rst && lat_we && !acc_err;

  // Memory contents survive reset, so the array lives outside the reset branch.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_be[i]) mem[idx][8*i +: 8] <= lat_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            cnt       <= 4'(LATENCY);
            req_ready <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            rsp_valid <= 1'b1;
            rsp_err   <= acc_err;
            rsp_rdata <= (!acc_err && !lat_we) ? mem[idx] : '0;
            state     <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: LATENCY=2 instance for directed/random traffic, LATENCY=0 instance for back-to-back.
module tb_data_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [31:0] rsp_rdata;

  logic        req_valid0 = 1'b0, req_ready0, req_we0 = 1'b0;
  logic [31:0] req_addr0 = '0, req_wdata0 = '0;
  logic [3:0]  req_be0 = '0;
  logic        rsp_valid0, rsp_ready0 = 1'b1, rsp_err0;
  logic [31:0] rsp_rdata0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] ref_mem [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .DEPTH_LOG2(8), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

  data_mem_responder #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .DEPTH_LOG2(8), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .req_be(req_be0), .rsp_valid(rsp_valid0),
    .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0));

  // Reference: a 256-word byte-laned memory; misaligned or >= 1 KiB addresses are errors.
  function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, output logic [31:0] rd, output logic er);
    er = (addr[1:0] != 2'b00) || (addr >= 32'd1024);
    rd = 32'd0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) ref_mem[addr[9:2]][8*i +: 8] = wdata[8*i +: 8];
      end else begin
        rd = ref_mem[addr[9:2]];
      end
    end
  endfunction

  // Drives one request on the LATENCY=2 instance and returns edges from accept to rsp_valid (-1 on timeout).
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                     output int lat, output logic [31:0] rdata, output logic err);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    lat = -1; rdata = 32'hx; err = 1'bx;
    if (rsp_valid) begin
      lat = 0; rdata = rsp_rdata; err = rsp_err;
    end else begin
      for (int c = 1; c <= 40; c++) begin
        @(posedge clk); #1;
        if (rsp_valid) begin
          lat = c; rdata = rsp_rdata; err = rsp_err;
          break;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
    checks++; if (req_ready0 !== 1'b1) begin errors++; $display("FAIL reset_req_ready0 got=%b exp=1", req_ready0); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL idle_after_reset valid=%b ready=%b exp 0/1", rsp_valid, req_ready); end
  endtask

  task automatic test_store_load;
    int lat; logic [31:0] rd, erd; logic er, eer;
    model(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, erd, eer);
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, er);
    checks++; if (lat !== LAT + 1) begin errors++; $display("FAIL store_latency got=%0d exp=%0d", lat, LAT + 1); end
    checks++; if (er !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL store_rsp err=%b rdata=%h exp 0/0", er, rd); end
    model(1'b0, 32'h10, 32'd0, 4'h0, erd, eer);
    txn(1'b0, 32'h10, 32'd0, 4'h0, lat, rd, er);
    checks++; if (lat !== LAT + 1) begin errors++; $display("FAIL load_latency got=%0d exp=%0d", lat, LAT + 1); end
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL load_data got=%h/%b exp=deadbeef/0", rd, er); end
  endtask

  task automatic test_partial_store;
    int lat; logic [31:0] rd, erd; logic er, eer;
    model(1'b1, 32'h10, 32'h0000AA00, 4'b0010, erd, eer);
    txn(1'b1, 32'h10, 32'h0000AA00, 4'b0010, lat, rd, er);
    checks++; if (er !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL partial_store_rsp err=%b rdata=%h exp 0/0", er, rd); end
    model(1'b0, 32'h10, 32'd0, 4'h0, erd, eer);
    txn(1'b0, 32'h10, 32'd0, 4'hF, lat, rd, er);
    checks++; if (rd !== 32'hDEADAAEF) begin errors++; $display("FAIL partial_merge got=%h exp=deadaaef", rd); end
    checks++; if (rd !== erd) begin errors++; $display("FAIL partial_model got=%h exp=%h", rd, erd); end
  endtask

  task automatic test_errors;
    int lat; logic [31:0] rd, erd; logic er, eer;
    model(1'b1, 32'h0, 32'h0BADF00D, 4'hF, erd, eer);
    txn(1'b1, 32'h0, 32'h0BADF00D, 4'hF, lat, rd, er);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL word0_store_err got=%b exp=0", er); end
    txn(1'b0, 32'h13, 32'd0, 4'hF, lat, rd, er);
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL misaligned_load err=%b rdata=%h exp 1/0", er, rd); end
    checks++; if (lat !== LAT + 1) begin errors++; $display("FAIL error_latency got=%0d exp=%0d", lat, LAT + 1); end
    txn(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, lat, rd, er);
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL range_store err=%b rdata=%h exp 1/0", er, rd); end
    txn(1'b0, 32'h0, 32'd0, 4'h0, lat, rd, er);
    checks++; if (rd !== 32'h0BADF00D || er !== 1'b0) begin errors++; $display("FAIL word0_after_range got=%h/%b exp=0badf00d/0", rd, er); end
    txn(1'b1, 32'h0, 32'h12345678, 4'h0, lat, rd, er);
    checks++; if (er !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL be0_store err=%b rdata=%h exp 0/0", er, rd); end
    txn(1'b0, 32'h0, 32'd0, 4'h0, lat, rd, er);
    checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL be0_unchanged got=%h exp=0badf00d", rd); end
  endtask

  task automatic test_backpressure;
    int lat; logic [31:0] rd, erd; logic er, eer;
    model(1'b0, 32'h10, 32'd0, 4'h0, erd, eer);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 0; c < 20 && !rsp_valid; c++) begin @(posedge clk); #1; end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout rsp_valid=%b exp=1", rsp_valid); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_valid = 1'($urandom_range(0, 1)); req_we = 1'b1; req_addr = 32'h10; req_wdata = $urandom; req_be = 4'hF;
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL bp_hold c=%0d valid=%b ready=%b exp 1/0", c, rsp_valid, req_ready); end
      checks++; if (rsp_rdata !== erd || rsp_err !== 1'b0) begin errors++; $display("FAIL bp_stable c=%0d rdata=%h err=%b exp %h/0", c, rsp_rdata, rsp_err, erd); end
    end
    @(negedge clk); req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'd0) begin
      errors++; $display("FAIL bp_release valid=%b ready=%b rdata=%h exp 0/1/0", rsp_valid, req_ready, rsp_rdata);
    end
    txn(1'b0, 32'h10, 32'd0, 4'h0, lat, rd, er);
    checks++; if (rd !== erd) begin errors++; $display("FAIL bp_ignored_store got=%h exp=%h", rd, erd); end
  endtask

  task automatic test_reset_mid;
    int lat; logic [31:0] rd, erd; logic er, eer;
    model(1'b1, 32'h20, 32'd0, 4'hF, erd, eer);
    txn(1'b1, 32'h20, 32'd0, 4'hF, lat, rd, er);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL wait_reset ready=%b valid=%b rdata=%h err=%b exp 1/0/0/0", req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    @(negedge clk); rst = 1'b0;
    txn(1'b0, 32'h20, 32'd0, 4'h0, lat, rd, er);
    checks++; if (rd !== 32'd0 || er !== 1'b0) begin errors++; $display("FAIL dropped_store got=%h/%b exp=0/0", rd, er); end
    // Reset while the response is being held: the store already landed.
    model(1'b1, 32'h24, 32'hCAFEF00D, 4'hF, erd, eer);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h24; req_wdata = 32'hCAFEF00D; req_be = 4'hF; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 0; c < 20 && !rsp_valid; c++) begin @(posedge clk); #1; end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL resp_reset_timeout rsp_valid=%b exp=1", rsp_valid); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL resp_reset valid=%b ready=%b exp 0/1", rsp_valid, req_ready); end
    @(negedge clk); rst = 1'b0; rsp_ready = 1'b1;
    txn(1'b0, 32'h24, 32'd0, 4'h0, lat, rd, er);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL persisted_store got=%h exp=cafef00d", rd); end
  endtask

  task automatic test_random;
    int lat; logic [31:0] rd, erd, a, d; logic er, eer, we; logic [3:0] be; int r;
    for (int w = 32; w < 48; w++) begin
      d = $urandom;
      model(1'b1, 32'(w * 4), d, 4'hF, erd, eer);
      txn(1'b1, 32'(w * 4), d, 4'hF, lat, rd, er);
      checks++; if (er !== eer || rd !== erd) begin errors++; $display("FAIL fill w=%0d got=%h/%b exp=%h/%b", w, rd, er, erd, eer); end
    end
    for (int n = 0; n < 40; n++) begin
      r  = $urandom_range(0, 9);
      a  = 32'($urandom_range(32, 47) * 4);
      if (r == 0) a = a | 32'($urandom_range(1, 3));
      if (r == 1) a = $urandom | 32'h400;
      we = 1'($urandom_range(0, 1));
      d  = $urandom;
      be = 4'($urandom);
      model(we, a, d, be, erd, eer);
      txn(we, a, d, be, lat, rd, er);
      checks++;
      if (lat !== LAT + 1 || rd !== erd || er !== eer) begin
        errors++; $display("FAIL random n=%0d we=%b addr=%h lat=%0d rdata=%h err=%b exp lat=%0d rdata=%h err=%b",
                           n, we, a, lat, rd, er, LAT + 1, erd, eer);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] m0 [4];
    logic [31:0] exp, d;
    logic [3:0]  b;
    logic        we;
    int          wi, prev, t_acc, guard;
    prev = -1;
    req_valid0 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      guard = 0;
      while (!req_ready0 && guard < 10) begin @(negedge clk); guard++; end
      checks++; if (req_ready0 !== 1'b1) begin errors++; $display("FAIL b2b_ready_timeout k=%0d ready=%b exp=1", k, req_ready0); end
      we = (k < 4) ? 1'b1 : 1'($urandom_range(0, 1));
      wi = (k < 4) ? k : $urandom_range(0, 3);
      d  = $urandom;
      b  = (k < 4) ? 4'hF : 4'($urandom);
      exp = 32'd0;
      if (we) begin
        for (int i = 0; i < 4; i++) if (b[i]) m0[wi][8*i +: 8] = d[8*i +: 8];
      end else begin
        exp = m0[wi];
      end
      req_we0 = we; req_addr0 = 32'(wi * 4); req_wdata0 = d; req_be0 = b;
      @(posedge clk); #1;
      t_acc = cyc;
      if (prev >= 0) begin
        checks++; if (t_acc - prev !== 3) begin errors++; $display("FAIL b2b_spacing k=%0d got=%0d exp=3", k, t_acc - prev); end
      end
      prev = t_acc;
      @(posedge clk); #1;
      checks++; if (rsp_valid0 !== 1'b1) begin errors++; $display("FAIL b2b_latency k=%0d rsp_valid=%b exp=1", k, rsp_valid0); end
      checks++; if (rsp_rdata0 !== exp || rsp_err0 !== 1'b0) begin
        errors++; $display("FAIL b2b_data k=%0d got=%h/%b exp=%h/0", k, rsp_rdata0, rsp_err0, exp);
      end
    end
    req_valid0 = 1'b0;
  endtask

  initial begin
    test_reset;
    test_store_load;
    test_partial_store;
    test_errors;
    test_backpressure;
    test_reset_mid;
    test_random;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cycles=%0d exp=finish", cyc);
    $fatal(1);
  end

endmodule
